// File: rtl/axi_stream_strip_header.sv
// Strips a 1..DATA_BYTE_WD byte header from the front of an AXI-Stream packet,
// realigns the payload onto full beats and presents the header LSB-aligned.
module axi_stream_strip_header #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD:0]    strip_len,
    output logic                    ready_strip,
    output logic                    header_valid,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header
);

    localparam int unsigned NW    = BYTE_CNT_WD + 1;
    localparam int unsigned SH_WD = $clog2(DATA_WD) + 1;
    localparam logic [NW-1:0]           BW_N     = NW'(DATA_BYTE_WD);
    localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY, S_FLUSH} state_t;

    function automatic logic [NW-1:0] f_popcnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [NW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            c = c + NW'(k[i]);
        end
        return c;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_msb_mask(input logic [NW-1:0] c);
        return ~(KEEP_ALL >> c);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_lsb_mask(input logic [NW-1:0] c);
        return ~(KEEP_ALL << c);
    endfunction

    function automatic logic [DATA_WD-1:0] f_byte_expand(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
            m[i*8 +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    state_t                  r_state, w_state_nxt;
    logic [NW-1:0]           r_n, w_n_nxt;
    logic [DATA_WD-1:0]      r_res, w_res_nxt;
    logic [NW-1:0]           r_fcnt, w_fcnt_nxt;
    logic                    r_valid_out, w_vo_nxt;
    logic [DATA_WD-1:0]      r_data_out, w_do_nxt;
    logic [DATA_BYTE_WD-1:0] r_keep_out, w_ko_nxt;
    logic                    r_last_out, w_lo_nxt;
    logic                    r_header_valid, w_hv_nxt;
    logic [DATA_WD-1:0]      r_header_out, w_ho_nxt;
    logic [DATA_BYTE_WD-1:0] r_keep_header, w_kh_nxt;

    logic [DATA_WD-1:0] w_din_m;
    logic [NW-1:0]      w_k;
    logic [NW-1:0]      w_clamp;
    logic [SH_WD-1:0]   w_sh_n;
    logic [SH_WD-1:0]   w_sh_rem;
    logic [DATA_WD-1:0] w_head;
    logic [DATA_WD-1:0] w_res_new;
    logic [DATA_WD-1:0] w_body;
    logic               w_out_free;
    logic               w_acc;

    // Invalid input bytes are zeroed up front so they never reach data_out.
    assign w_din_m   = data_in & f_byte_expand(keep_in);
    assign w_k       = f_popcnt(keep_in);
    assign w_clamp   = (strip_len > BW_N) ? BW_N : strip_len;
    assign w_sh_n    = SH_WD'({r_n, 3'b000});
    assign w_sh_rem  = SH_WD'({BW_N - r_n, 3'b000});
    assign w_head    = w_din_m >> w_sh_rem;
    assign w_res_new = w_din_m << w_sh_n;
    assign w_body    = r_res | (w_din_m >> w_sh_rem);

    assign w_out_free  = !r_valid_out || ready_out;
    assign ready_strip = (r_state == S_IDLE);
    assign ready_in    = (r_state == S_FIRST) || ((r_state == S_BODY) && w_out_free);
    assign w_acc       = valid_in && ready_in;

    // Next-state, residue and output-register loading.
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_res_nxt   = r_res;
        w_fcnt_nxt  = r_fcnt;
        w_vo_nxt    = w_out_free ? 1'b0 : r_valid_out;
        w_do_nxt    = r_data_out;
        w_ko_nxt    = r_keep_out;
        w_lo_nxt    = r_last_out;
        w_hv_nxt    = 1'b0;
        w_ho_nxt    = r_header_out;
        w_kh_nxt    = r_keep_header;
        case (r_state)
            S_IDLE: begin
                if (valid_strip) begin
                    w_n_nxt     = w_clamp;
                    w_state_nxt = S_FIRST;
                end
            end
            S_FIRST: begin
                if (w_acc) begin
                    if (r_n != '0) begin
                        w_hv_nxt = 1'b1;
                        w_ho_nxt = w_head;
                        w_kh_nxt = f_lsb_mask(r_n);
                    end
                    w_res_nxt = w_res_new;
                    if (!last_in) begin
                        w_state_nxt = S_BODY;
                    end else if (w_k > r_n) begin
                        // Previous packet's last beat may still occupy the output register.
                        if (w_out_free) begin
                            w_vo_nxt    = 1'b1;
                            w_do_nxt    = w_res_new;
                            w_ko_nxt    = f_msb_mask(w_k - r_n);
                            w_lo_nxt    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_fcnt_nxt  = w_k - r_n;
                            w_state_nxt = S_FLUSH;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BODY: begin
                if (w_acc) begin
                    w_vo_nxt  = 1'b1;
                    w_do_nxt  = w_body;
                    w_res_nxt = w_res_new;
                    if (!last_in) begin
                        w_ko_nxt = KEEP_ALL;
                        w_lo_nxt = 1'b0;
                    end else if (w_k <= r_n) begin
                        w_ko_nxt    = f_msb_mask(BW_N - r_n + w_k);
                        w_lo_nxt    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ko_nxt    = KEEP_ALL;
                        w_lo_nxt    = 1'b0;
                        w_fcnt_nxt  = w_k - r_n;
                        w_state_nxt = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (w_out_free) begin
                    w_vo_nxt    = 1'b1;
                    w_do_nxt    = r_res;
                    w_ko_nxt    = f_msb_mask(r_fcnt);
                    w_lo_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_n            <= '0;
            r_res          <= '0;
            r_fcnt         <= '0;
            r_valid_out    <= 1'b0;
            r_data_out     <= '0;
            r_keep_out     <= '0;
            r_last_out     <= 1'b0;
            r_header_valid <= 1'b0;
            r_header_out   <= '0;
            r_keep_header  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_n            <= w_n_nxt;
            r_res          <= w_res_nxt;
            r_fcnt         <= w_fcnt_nxt;
            r_valid_out    <= w_vo_nxt;
            r_data_out     <= w_do_nxt;
            r_keep_out     <= w_ko_nxt;
            r_last_out     <= w_lo_nxt;
            r_header_valid <= w_hv_nxt;
            r_header_out   <= w_ho_nxt;
            r_keep_header  <= w_kh_nxt;
        end
    end

    assign valid_out    = r_valid_out;
    assign data_out     = r_data_out;
    assign keep_out     = r_keep_out;
    assign last_out     = r_last_out;
    assign header_valid = r_header_valid;
    assign header_out   = r_header_out;
    assign keep_header  = r_keep_header;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header with a byte-level model for the random phase.
module tb_axi_stream_strip_header;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_strip;
    logic [2:0]  strip_len;
    logic        ready_strip;
    logic        header_valid;
    logic [31:0] header_out;
    logic [3:0]  keep_header;

    logic bp_fixed;
    logic bp_rand;
    logic rnd_mode;
    assign ready_out = rnd_mode ? bp_rand : bp_fixed;

    int total;
    int bad;

    logic [31:0] obs_d [$];
    logic [3:0]  obs_k [$];
    logic        obs_l [$];
    logic [31:0] hdr_d [$];
    logic [3:0]  hdr_k [$];
    logic [31:0] exp_d [$];
    logic [3:0]  exp_k [$];
    logic        exp_l [$];
    logic [31:0] exh_d [$];
    logic [3:0]  exh_k [$];

    axi_stream_strip_header dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_strip(valid_strip), .strip_len(strip_len), .ready_strip(ready_strip),
        .header_valid(header_valid), .header_out(header_out), .keep_header(keep_header)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bp_rand <= ($urandom_range(0, 3) != 0);

    // Records output handshakes and header pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) begin
            obs_d.push_back(data_out);
            obs_k.push_back(keep_out);
            obs_l.push_back(last_out);
        end
        if (rst_n && header_valid) begin
            hdr_d.push_back(header_out);
            hdr_k.push_back(keep_header);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strip(input logic [2:0] l);
        logic acc;
        valid_strip = 1'b1;
        strip_len   = l;
        acc = 1'b0;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = ready_strip;
            @(posedge clk);
            #1;
        end
        valid_strip = 1'b0;
        chk("strip_handshake", 64'(acc), 64'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic acc;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        acc = 1'b0;
        for (int c = 0; c < 300 && !acc; c++) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        chk("beat_accept", 64'(acc), 64'd1);
    endtask

    task automatic clear_obs();
        obs_d.delete(); obs_k.delete(); obs_l.delete();
        hdr_d.delete(); hdr_k.delete();
    endtask

    logic [31:0] rd;
    logic [31:0] rh;
    logic [31:0] cd;
    logic [3:0]  rk;
    logic [3:0]  ck;
    logic [7:0]  pq [$];
    logic [3:0]  full_mask;
    int          sl, n, len, kk, cnt, lim;

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_strip = 1'b0; strip_len = '0; bp_fixed = 1'b1; rnd_mode = 1'b0;
        full_mask = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 64'(valid_out), 0);
        chk("rst_data_out", 64'(data_out), 0);
        chk("rst_keep_out", 64'(keep_out), 0);
        chk("rst_last_out", 64'(last_out), 0);
        chk("rst_header_valid", 64'(header_valid), 0);
        chk("rst_header_out", 64'(header_out), 0);
        chk("rst_keep_header", 64'(keep_header), 0);
        chk("rst_ready_strip", 64'(ready_strip), 1);
        chk("rst_ready_in", 64'(ready_in), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // N=2, three-beat packet
        strip(3'd2);
        chk("n2_ready_in", 64'(ready_in), 1);
        send(32'hAABBCCDD, 4'hF, 1'b0);
        chk("n2_hv", 64'(header_valid), 1);
        chk("n2_hdr", 64'(header_out), 64'h0000AABB);
        chk("n2_khdr", 64'(keep_header), 64'h3);
        chk("n2_no_out_yet", 64'(valid_out), 0);
        send(32'h11223344, 4'hF, 1'b0);
        chk("n2_b0", {31'd0, valid_out, data_out, keep_out, last_out}, {31'd0, 1'b1, 32'hCCDD1122, 4'hF, 1'b0});
        chk("n2_hv_pulse", 64'(header_valid), 0);
        send(32'h55667788, 4'hC, 1'b1);
        chk("n2_b1", {31'd0, valid_out, data_out, keep_out, last_out}, {31'd0, 1'b1, 32'h33445566, 4'hF, 1'b1});
        chk("n2_ready_strip", 64'(ready_strip), 1);
        tick();
        chk("n2_idle_valid", 64'(valid_out), 0);

        // N=1, ends in a flush beat
        strip(3'd1);
        send(32'hAABBCCDD, 4'hF, 1'b0);
        chk("n1_hdr", {header_valid, header_out, keep_header}, {1'b1, 32'h000000AA, 4'h1});
        send(32'h11223344, 4'hE, 1'b1);
        chk("n1_b0", {31'd0, valid_out, data_out, keep_out, last_out}, {31'd0, 1'b1, 32'hBBCCDD11, 4'hF, 1'b0});
        chk("n1_flush_ready_in", 64'(ready_in), 0);
        tick();
        chk("n1_flush", {31'd0, valid_out, data_out, keep_out, last_out}, {31'd0, 1'b1, 32'h22330000, 4'hC, 1'b1});
        tick();
        chk("n1_after_flush", 64'(valid_out), 0);

        // N=4, header-only single beat
        clear_obs();
        strip(3'd4);
        send(32'hAABBCCDD, 4'hF, 1'b1);
        chk("n4_hdr", {header_valid, header_out, keep_header}, {1'b1, 32'hAABBCCDD, 4'hF});
        chk("n4_no_valid", 64'(valid_out), 0);
        chk("n4_ready_strip", 64'(ready_strip), 1);
        tick();
        chk("n4_no_beats", 64'(obs_d.size()), 0);

        // N=3, five beats with a 3-cycle stall
        clear_obs();
        strip(3'd3);
        send(32'h01020304, 4'hF, 1'b0);
        chk("bp_hdr", {header_out, keep_header}, {32'h00010203, 4'h7});
        send(32'h05060708, 4'hF, 1'b0);
        bp_fixed = 1'b0;
        valid_in = 1'b1; data_in = 32'h090A0B0C; keep_in = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", {31'd0, valid_out, data_out, keep_out, last_out}, {31'd0, 1'b1, 32'h04050607, 4'hF, 1'b0});
            chk("bp_ready_in", 64'(ready_in), 0);
        end
        bp_fixed = 1'b1;
        send(32'h090A0B0C, 4'hF, 1'b0);
        send(32'h0D0E0F10, 4'hF, 1'b0);
        send(32'h11223344, 4'h8, 1'b1);
        repeat (3) tick();
        chk("bp_count", 64'(obs_d.size()), 4);
        if (obs_d.size() == 4) begin
            chk("bp_o0", {obs_d[0], obs_k[0], obs_l[0]}, {32'h04050607, 4'hF, 1'b0});
            chk("bp_o1", {obs_d[1], obs_k[1], obs_l[1]}, {32'h08090A0B, 4'hF, 1'b0});
            chk("bp_o2", {obs_d[2], obs_k[2], obs_l[2]}, {32'h0C0D0E0F, 4'hF, 1'b0});
            chk("bp_o3", {obs_d[3], obs_k[3], obs_l[3]}, {32'h10110000, 4'hC, 1'b1});
        end

        // Reset after two beats
        clear_obs();
        strip(3'd2);
        send(32'hAABBCCDD, 4'hF, 1'b0);
        send(32'h11223344, 4'hF, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_outs", {valid_out, data_out, keep_out, last_out, header_valid},
            {1'b0, 32'h0, 4'h0, 1'b0, 1'b0});
        chk("mr_hdr", {header_out, keep_header}, {32'h0, 4'h0});
        chk("mr_ready", {ready_strip, ready_in}, {1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        obs_d.delete(); obs_k.delete(); obs_l.delete();
        repeat (3) tick();
        chk("mr_no_beats", 64'(obs_d.size()), 0);
        strip(3'd2);
        send(32'hAABBCCDD, 4'hF, 1'b0);
        chk("mr_hdr2", {header_valid, header_out, keep_header}, {1'b1, 32'h0000AABB, 4'h3});
        send(32'h11223344, 4'hF, 1'b0);
        chk("mr_b0", {valid_out, data_out, keep_out}, {1'b1, 32'hCCDD1122, 4'hF});
        send(32'h55667788, 4'hC, 1'b1);
        chk("mr_b1", {valid_out, data_out, keep_out, last_out}, {1'b1, 32'h33445566, 4'hF, 1'b1});
        tick();

        // Random back-to-back packets against a byte-queue model
        clear_obs();
        rnd_mode = 1'b1;
        for (int p = 0; p < 50; p++) begin
            sl  = $urandom_range(1, 7);
            n   = (sl > 4) ? 4 : sl;
            len = $urandom_range(1, 5);
            pq.delete();
            strip(3'(sl));
            for (int b = 0; b < len; b++) begin
                rd = $urandom;
                kk = 4;
                if (b == len - 1) kk = (len == 1) ? $urandom_range(n, 4) : $urandom_range(1, 4);
                rk = full_mask << (4 - kk);
                for (int i = 0; i < kk; i++) pq.push_back(rd[31 - 8*i -: 8]);
                send(rd, rk, (b == len - 1));
            end
            rh = '0;
            for (int i = 0; i < n; i++) rh = {rh[23:0], pq[i]};
            exh_d.push_back(rh);
            rk = ~(full_mask << n);
            exh_k.push_back(rk);
            for (int i = n; i < pq.size(); i += 4) begin
                cd = '0;
                cnt = 0;
                for (int j = 0; j < 4; j++) begin
                    if (i + j < pq.size()) begin
                        cd[31 - 8*j -: 8] = pq[i + j];
                        cnt++;
                    end
                end
                ck = full_mask << (4 - cnt);
                exp_d.push_back(cd);
                exp_k.push_back(ck);
                exp_l.push_back(i + 4 >= pq.size());
            end
        end
        for (int c = 0; c < 500 && obs_d.size() < exp_d.size(); c++) tick();
        repeat (5) tick();
        rnd_mode = 1'b0;
        chk("rnd_beat_count", 64'(obs_d.size()), 64'(exp_d.size()));
        chk("rnd_hdr_count", 64'(hdr_d.size()), 64'(exh_d.size()));
        lim = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < lim; i++)
            chk($sformatf("rnd_beat%0d", i), {obs_d[i], obs_k[i], obs_l[i]}, {exp_d[i], exp_k[i], exp_l[i]});
        lim = (hdr_d.size() < exh_d.size()) ? hdr_d.size() : exh_d.size();
        for (int i = 0; i < lim; i++)
            chk($sformatf("rnd_hdr%0d", i), {hdr_d[i], hdr_k[i]}, {exh_d[i], exh_k[i]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_stream_strip_header.md
# axi_stream_strip_header

Removes a per-packet header of 1..DATA_BYTE_WD bytes from the front of an AXI-Stream packet and realigns the remaining payload onto full output beats. It is the receive-side counterpart of `axi_stream_insert_header` and sits directly downstream of it in the loopback datapath. The stripped header is presented on a side port, LSB-aligned, in the same format `axi_stream_insert_header` accepts.

## Interface
Parameters:
- DATA_WD, 32: data width in bits.
- DATA_BYTE_WD, DATA_WD/8: bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD): byte-count width; strip_len is BYTE_CNT_WD+1 bits.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- valid_in  in  1  input beat valid.
- data_in  in  DATA_WD  input data; byte order is MSB first, data[DATA_WD-1 -: 8] is the first byte.
- keep_in  in  DATA_BYTE_WD  input byte enables, MSB-aligned; all ones except possibly on the last beat.
- last_in  in  1  last beat of the packet.
- ready_in  out  1  input beat accepted when valid_in && ready_in.
- valid_out  out  1  output beat valid, registered.
- data_out  out  DATA_WD  realigned payload; invalid bytes driven 0.
- keep_out  out  DATA_BYTE_WD  output byte enables, MSB-aligned.
- last_out  out  1  last payload beat.
- ready_out  in  1  downstream ready.
- valid_strip  in  1  strip-length request valid.
- strip_len  in  BYTE_CNT_WD+1  header length N in bytes.
- ready_strip  out  1  high only in IDLE.
- header_valid  out  1  one-cycle pulse when header_out/keep_header update.
- header_out  out  DATA_WD  stripped header, LSB-aligned.
- keep_header  out  DATA_BYTE_WD  low N bits set.

## Operation
- **Strip length.** N is latched on valid_strip && ready_strip.
  - N = 0: the packet passes through unchanged; header_valid does not pulse.
  - N > DATA_BYTE_WD: clamped to DATA_BYTE_WD.
- **FSM states:** IDLE, FIRST, BODY, FLUSH.
- **IDLE.** ready_strip = 1, ready_in = 0. On the strip handshake, go to FIRST.
- **FIRST.** ready_in = 1. On the accepted beat:
  - header_out = the first N bytes, LSB-aligned; keep_header is set; header_valid pulses.
  - The residue register captures the remaining DATA_BYTE_WD-N bytes.
  - If last_in is also set, see the end-of-packet rules below. Otherwise go to BODY.
- **BODY.** ready_in = !valid_out || ready_out. On each accepted beat:
  - Output beat = {residue, first N bytes of the new beat}.
  - New residue = the last DATA_BYTE_WD-N bytes of the new beat.
  - For N = DATA_BYTE_WD the residue is empty and the beat passes straight through.
- **End of packet.** Let K be the number of valid bytes on the last input beat (popcount of keep_in).
  - In BODY, K <= N: a single final beat with DATA_BYTE_WD-N+K bytes and last_out = 1; go to IDLE.
  - In BODY, K > N: a full beat, then go to FLUSH to emit K-N residue bytes with last_out = 1.
  - First beat is also last, K <= N: no payload beat is produced; go to IDLE.
  - First beat is also last, K > N: one beat of K-N bytes with last_out = 1; go to IDLE.
- **FLUSH.** ready_in = 0. Load the residue beat when the output register is free, then go to IDLE.
- **Output register.** Loads when !valid_out || ready_out. While valid_out && !ready_out, it holds data_out, keep_out and last_out stable.
- keep_out is always MSB-aligned ones. A packet with valid_out and no last_out never ends mid-packet.

## Timing
- **Reset values.** valid_out = 0, data_out = 0, keep_out = 0, last_out = 0, header_valid = 0, header_out = 0, keep_header = 0. State = IDLE, so ready_strip = 1 and ready_in = 0.
- **Reset mid-packet.** State, residue and output register clear immediately. Any partial packet is dropped and no last_out is emitted.
- **Strip handshake to ready_in.** ready_in goes high one cycle after the strip handshake.
- **Header latency.** header_valid is high the cycle after the first beat is accepted.
- **Payload latency.** Each output beat is valid the cycle after the input beat that completes it is accepted. A FLUSH beat adds one cycle.
- **Throughput.** One beat per cycle in BODY with ready_out held high.
- **Packet gap.** The minimum gap between packets is 1 cycle: IDLE, plus FLUSH when it occurs.
- **Overlap.** The strip handshake for the next packet may occur while the last beat of the previous packet is still waiting in the output register.
- valid_in is ignored outside FIRST and BODY.

## Test plan
- **N=2.** Input beats 0xAABBCCDD, 0x11223344, then 0x55667788 with keep 1100 and last.
  - header_out = 0x0000AABB, keep_header = 0011.
  - Output: 0xCCDD1122 / 1111, then 0x33445566 / 1111 with last.
- **N=1, flush case.** Input beats 0xAABBCCDD, then 0x11223344 with keep 1110 and last.
  - header_out = 0x000000AA, keep_header = 0001.
  - Output: 0xBBCCDD11 / 1111, then FLUSH beat 0x22330000 / 1100 with last.
- **N=4, header only.** Single beat 0xAABBCCDD with keep 1111 and last.
  - header_out = 0xAABBCCDD, keep_header = 1111.
  - No valid_out; ready_strip returns high 1 cycle after the beat.
- **Backpressure.** N=3, 5-beat packet, ready_out held low for 3 cycles mid-packet.
  - data_out, keep_out and last_out stay stable; ready_in stays low.
  - No bytes lost or duplicated, checked against a scoreboard.
- **Reset mid-packet.** Assert rst_n low after 2 beats.
  - All outputs go to their reset values immediately and ready_strip = 1.
  - The next packet (N=2) strips correctly.
- **Back-to-back random.** 50 packets with random N in 1..4, random lengths and random ready_out, mirroring the `axi_stream_insert_header` bench.
  - Payload and headers must match the reference model.
